// File: rtl/keypad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_pkg : shared types and key-legend helper for the 4x4 keypad scanner
// Revision   : 1.0
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    SCAN_EMPTY  = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_result_t;

  // ASCII legend printed on the keycap for code = {col[1:0], row[1:0]}
  function automatic logic [7:0] kp_hex(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      4'h0: ch = "1";
      4'h1: ch = "4";
      4'h2: ch = "7";
      4'h3: ch = "*";
      4'h4: ch = "2";
      4'h5: ch = "5";
      4'h6: ch = "8";
      4'h7: ch = "0";
      4'h8: ch = "3";
      4'h9: ch = "6";
      4'hA: ch = "9";
      4'hB: ch = "#";
      4'hC: ch = "A";
      4'hD: ch = "B";
      4'hE: ch = "C";
      default: ch = "D";
    endcase
    return ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer for a bus of independent asynchronous bits
// Revision : 1.0
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_scanner : 4x4 matrix scan with whole-scan debounce, one pulse per press
// Revision       : 1.0
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int FREQUENCY      = 27_000_000,
  parameter int SCAN_MS        = 1,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DWELL = FREQUENCY * SCAN_MS / 1000;
  localparam int DW_W  = $clog2(DWELL);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);

  logic [3:0]      row_sync;
  logic [DW_W-1:0] dwell_cnt;
  logic [1:0]      col_idx;
  logic [1:0]      acc_cnt;
  logic [3:0]      acc_code;
  logic            scan_done;
  scan_result_t    scan_res;
  logic [3:0]      scan_code;
  kp_state_t       state;
  logic [3:0]      cand;
  logic [DB_W-1:0] db_cnt;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_n),
    .q   (row_sync)
  );

  logic       sample;
  logic [2:0] cur_cnt;
  logic [1:0] cur_row;
  logic [2:0] total_cnt;
  logic [1:0] merged_cnt;
  logic [3:0] merged_code;

  assign sample = (dwell_cnt == DWELL_LAST);

  // Fold this column's rows into the running snapshot; column 0 starts a fresh scan.
  always_comb begin
    cur_cnt = 3'd0;
    cur_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        cur_cnt = cur_cnt + 3'd1;
        cur_row = r[1:0];
      end
    end
    total_cnt   = ((col_idx == 2'd0) ? 3'd0 : 3'(acc_cnt)) + cur_cnt;
    merged_cnt  = (total_cnt >= 3'd2) ? 2'd2 : total_cnt[1:0];
    merged_code = (cur_cnt != 3'd0) ? {col_idx, cur_row} : acc_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      scan_done <= 1'b0;
      scan_res  <= SCAN_EMPTY;
      scan_code <= 4'd0;
    end else begin
      scan_done <= 1'b0;
      if (sample) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        col_n     <= {col_n[2:0], col_n[3]};
        acc_cnt   <= merged_cnt;
        acc_code  <= merged_code;
        if (col_idx == 2'd3) begin
          scan_done <= 1'b1;
          scan_code <= merged_code;
          case (merged_cnt)
            2'd0:    scan_res <= SCAN_EMPTY;
            2'd1:    scan_res <= SCAN_SINGLE;
            default: scan_res <= SCAN_MULTI;
          endcase
        end
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
    end
  end

  logic is_single;
  logic hit_cand;
  logic hit_key;

  // MULTI never matches a code, so it behaves exactly like EMPTY below.
  assign is_single = (scan_res == SCAN_SINGLE);
  assign hit_cand  = is_single && (scan_code == cand);
  assign hit_key   = is_single && (scan_code == key_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      db_cnt    <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        unique case (state)
          IDLE: begin
            if (is_single) begin
              state  <= CONFIRM;
              cand   <= scan_code;
              db_cnt <= DB_ONE;
            end
          end
          CONFIRM: begin
            if (hit_cand) begin
              if (db_cnt == DB_LAST) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                db_cnt    <= '0;
              end else begin
                db_cnt <= db_cnt + 1'b1;
              end
            end else if (is_single) begin
              cand   <= scan_code;
              db_cnt <= DB_ONE;
            end else begin
              state  <= IDLE;
              db_cnt <= '0;
            end
          end
          PRESSED: begin
            if (!hit_key) begin
              state  <= RELEASE;
              db_cnt <= DB_ONE;
            end
          end
          RELEASE: begin
            if (hit_key) begin
              state  <= PRESSED;
              db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
              state    <= IDLE;
              key_held <= 1'b0;
              db_cnt   <= '0;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
